// File: rtl/bs_pkg.sv
// Shared Battleship definitions: board size, debounce default, shot FSM states
// and the one-hot test used when validating a shot.
package bs_pkg;

    localparam int N_CELLS           = 10;
    localparam int DB_CYCLES_DEFAULT = 500000;
    localparam int MAX_CELLS         = 64;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVAL     = 2'd1,
        WAIT_REL = 2'd2
    } shot_state_t;

    // True when exactly one bit of v is set; narrower vectors are zero-extended by the caller.
    function automatic logic popcount_is_one(input logic [MAX_CELLS-1:0] v);
        int cnt;
        cnt = 0;
        for (int i = 0; i < MAX_CELLS; i++) begin
            cnt = cnt + int'(v[i]);
        end
        return (cnt == 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stability counter for a raw push button; the
// debounced level only moves after DB_CYCLES consecutive cycles of disagreement.
module btn_debounce
    import bs_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic clr,
    input  logic btn_raw,
    output logic btn_db
);

    localparam int                CW       = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]     CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          db_q;
    logic          db_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            // The last disagreeing cycle flips the level instead of counting further.
            if (cnt_q == CNT_LAST) begin
                db_d  = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_db = db_q;

endmodule

// File: rtl/shot_validator.sv
// Attack-entry front end: synchronizes switches, debounces fire, and accepts a
// press only when it adds exactly one new cell to the retained shot history.
module shot_validator
    import bs_pkg::*;
#(
    parameter int N         = N_CELLS,
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic [N-1:0]               sw,
    input  logic                       fire,
    output logic [N-1:0]               shot,
    output logic [N-1:0]               hist,
    output logic                       ok,
    output logic                       err,
    output logic [$clog2(N+1)-1:0]     shot_cnt,
    output logic                       full
);

    localparam int               CNT_W   = $clog2(N + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N);

    logic [N-1:0]     sw_meta_q;
    logic [N-1:0]     sw_s_q;
    logic             fire_db;
    logic             fire_db_prev_q;

    shot_state_t      state_q;
    shot_state_t      state_d;
    logic [N-1:0]     hist_q;
    logic [N-1:0]     hist_d;
    logic [N-1:0]     shot_q;
    logic [N-1:0]     shot_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ok_q;
    logic             ok_d;
    logic             err_q;
    logic             err_d;

    logic [N-1:0]     new_cells;
    logic             full_w;
    logic             press_valid;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_fire_db (
        .clk     (clk),
        .clr     (clr),
        .btn_raw (fire),
        .btn_db  (fire_db)
    );

    assign new_cells   = sw_s_q & ~hist_q;
    assign full_w      = &hist_q;
    assign press_valid = ((sw_s_q & hist_q) == hist_q)
                         && popcount_is_one(MAX_CELLS'(new_cells))
                         && !full_w;

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        shot_d  = shot_q;
        cnt_d   = cnt_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (fire_db && !fire_db_prev_q) begin
                    state_d = EVAL;
                end
            end
            EVAL: begin
                state_d = WAIT_REL;
                if (press_valid) begin
                    hist_d = sw_s_q;
                    shot_d = new_cells;
                    ok_d   = 1'b1;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    err_d = 1'b1;
                end
            end
            WAIT_REL: begin
                // One evaluation per press: the debounced level must fall before re-arming.
                if (!fire_db) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sw_meta_q      <= '0;
            sw_s_q         <= '0;
            fire_db_prev_q <= 1'b0;
            state_q        <= IDLE;
            hist_q         <= '0;
            shot_q         <= '0;
            cnt_q          <= '0;
            ok_q           <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            sw_meta_q      <= sw;
            sw_s_q         <= sw_meta_q;
            fire_db_prev_q <= fire_db;
            state_q        <= state_d;
            hist_q         <= hist_d;
            shot_q         <= shot_d;
            cnt_q          <= cnt_d;
            ok_q           <= ok_d;
            err_q          <= err_d;
        end
    end

    assign shot     = shot_q;
    assign hist     = hist_q;
    assign ok       = ok_q;
    assign err      = err_q;
    assign shot_cnt = cnt_q;
    assign full     = full_w;

endmodule

// File: tb/tb_shot_validator.sv
// Directed and randomized checks of shot_validator against a set-based model
// of the shot history (DB_CYCLES = 4, N = 10).
module tb_shot_validator;

    localparam int N  = 10;
    localparam int DB = 4;

    logic         clk = 1'b0;
    logic         clr = 1'b1;
    logic [N-1:0] sw  = '0;
    logic         fire = 1'b0;
    logic [N-1:0] shot;
    logic [N-1:0] hist;
    logic         ok;
    logic         err;
    logic [3:0]   shot_cnt;
    logic         full;

    shot_validator #(.N(N), .DB_CYCLES(DB)) dut (
        .clk      (clk),
        .clr      (clr),
        .sw       (sw),
        .fire     (fire),
        .shot     (shot),
        .hist     (hist),
        .ok       (ok),
        .err      (err),
        .shot_cnt (shot_cnt),
        .full     (full)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int cyc0 = 0;
    int p_ok = 0;
    int p_err = 0;
    int p_first = -1;
    int excl_bad = 0;

    // Reference model: the set of accepted cells and the shot count.
    logic [N-1:0] m_hist = '0;
    logic [N-1:0] m_shot = '0;
    int           m_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            if (ok) begin
                p_ok++;
                if (p_first < 0) p_first = cyc - cyc0;
            end
            if (err) p_err++;
            if (ok && err) excl_bad++;
        end
    endtask

    task automatic clear_pulses();
        p_ok = 0;
        p_err = 0;
        p_first = -1;
        cyc0 = cyc;
    endtask

    // Clean press held for `hold` cycles, then released long enough to re-arm.
    task automatic press(input logic [N-1:0] s, input int hold);
        clear_pulses();
        sw   = s;
        fire = 1'b1;
        run(hold);
        fire = 1'b0;
        run(14);
    endtask

    // Applies the acceptance rule to the model; returns 1 if the press should be accepted.
    function automatic logic model_press(input logic [N-1:0] s);
        logic [N-1:0] added;
        added = s & ~m_hist;
        if (((s & m_hist) == m_hist) && ($countones(added) == 1) && (m_hist != '1)) begin
            m_hist = s;
            m_shot = added;
            m_cnt  = m_cnt + 1;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_hist = '0;
        m_shot = '0;
        m_cnt  = 0;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_hist"}, 32'(hist), 32'(m_hist));
        chk({tag, "_shot"}, 32'(shot), 32'(m_shot));
        chk({tag, "_cnt"},  32'(shot_cnt), 32'(m_cnt));
        chk({tag, "_full"}, 32'(full), 32'(m_hist == '1));
    endtask

    task automatic do_press(input string tag, input logic [N-1:0] s);
        logic acc;
        acc = model_press(s);
        press(s, 10);
        chk({tag, "_ok"},  32'(p_ok),  32'(acc ? 1 : 0));
        chk({tag, "_err"}, 32'(p_err), 32'(acc ? 0 : 1));
        chk_outputs(tag);
    endtask

    initial begin
        logic [N-1:0] s;
        int           c;
        int           iter;

        // Reset values with random switches.
        sw = N'($urandom);
        run(3);
        chk("rst_shot", 32'(shot), 0);
        chk("rst_hist", 32'(hist), 0);
        chk("rst_ok",   32'(ok), 0);
        chk("rst_err",  32'(err), 0);
        chk("rst_cnt",  32'(shot_cnt), 0);
        chk("rst_full", 32'(full), 0);
        clr = 1'b0;
        clear_pulses();
        for (int i = 0; i < 10; i++) begin
            sw = N'($urandom);
            run(5);
        end
        chk("idle_pulses", 32'(p_ok + p_err), 0);
        chk_outputs("idle");

        // Single valid shot: latency 2 + DB + 1 + 1 = 8 cycles.
        begin
            logic acc;
            acc = model_press(10'h004);
            press(10'h004, 20);
            chk("single_ok", 32'(p_ok), 32'(acc ? 1 : 0));
            chk("single_err", 32'(p_err), 0);
            chk("single_lat", 32'(p_first), 8);
            chk("single_shot_val", 32'(shot), 32'h004);
            chk_outputs("single");
        end

        // Invalid presses against hist = 0x004.
        do_press("two_new",   10'h01C);
        do_press("drop_prev", 10'h008);
        do_press("no_new",    10'h004);
        chk("inv_hist", 32'(hist), 32'h004);

        // Bounce for 20 cycles, then held high: exactly one evaluation.
        begin
            logic acc;
            acc = model_press(10'h006);
            clear_pulses();
            sw = 10'h006;
            for (int i = 0; i < 10; i++) begin
                fire = ~fire;
                run(2);
            end
            fire = 1'b1;
            run(15);
            fire = 1'b0;
            run(14);
            chk("bounce_ok", 32'(p_ok), 32'(acc ? 1 : 0));
            chk("bounce_err", 32'(p_err), 0);
            chk_outputs("bounce");
        end

        // Three-cycle glitches while idle never reach the debounced level.
        clear_pulses();
        sw = 10'h00E;
        for (int i = 0; i < 5; i++) begin
            fire = 1'b1;
            run(3);
            fire = 1'b0;
            run(8);
        end
        chk("glitch_pulses", 32'(p_ok + p_err), 0);
        chk_outputs("glitch");

        // Clear, then fill the board with a random mix of valid and invalid presses.
        clr = 1'b1;
        run(2);
        clr = 1'b0;
        model_reset();
        run(2);
        chk_outputs("clr2");
        iter = 0;
        while ((m_hist != '1) && (iter < 80)) begin
            if ($urandom_range(0, 2) != 0) begin
                c = $urandom_range(0, N - 1);
                while (m_hist[c]) c = (c + 1) % N;
                s = m_hist | (N'(1) << c);
            end else begin
                s = N'($urandom);
            end
            do_press("rand", s);
            iter++;
        end
        chk("fill_hist", 32'(hist), 32'h3FF);
        chk("fill_full", 32'(full), 1);
        chk("fill_cnt",  32'(shot_cnt), 10);
        do_press("eleventh", 10'h3FF);
        chk("sat_cnt", 32'(shot_cnt), 10);
        do_press("eleventh_rand", N'($urandom));

        // Clear in the EVAL cycle: no pulse, outputs zero, re-evaluation after debounce.
        clr = 1'b1;
        run(2);
        clr = 1'b0;
        model_reset();
        clear_pulses();
        sw   = 10'h004;
        fire = 1'b1;
        run(7);
        clr = 1'b1;
        #1;
        chk("mid_ok",   32'(ok), 0);
        chk("mid_err",  32'(err), 0);
        chk("mid_hist", 32'(hist), 0);
        chk("mid_cnt",  32'(shot_cnt), 0);
        run(2);
        chk("mid_pulses", 32'(p_ok + p_err), 0);
        clr = 1'b0;
        begin
            logic acc;
            acc = model_press(10'h004);
            clear_pulses();
            run(20);
            chk("mid_re_ok", 32'(p_ok), 32'(acc ? 1 : 0));
            chk("mid_re_lat", 32'(p_first), 8);
            chk_outputs("mid_re");
        end
        fire = 1'b0;
        run(14);

        chk("ok_err_exclusive", 32'(excl_bad), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
